// File: rtl/batch_stream_host.sv
// -----------------------------------------------------------------------------
// batch_stream_host
//
// Purpose
//   Runs one batch transfer for each accepted start pulse:
//     SEND : reads source words 0..ss from memory and streams them out on the
//            src master port. A 2-entry prefetch buffer lets the stream run at
//            one beat per cycle.
//     RECV : accepts dst stream beats and writes beat n to DST_BASE+n. The
//            phase ends on dst_last or on beat n==ds. err is set if exactly
//            one of those two conditions holds on the final beat.
//     DONE : one-cycle done pulse, then back to IDLE.
//
// Optional feature (macro STREAM_TIMEOUT_EN)
//   When the macro is defined, TMO_CYC consecutive RECV cycles without a dst
//   beat set err and end the batch. When it is undefined, RECV waits
//   indefinitely and no timeout counter is built.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   start, ss, ds             batch request; ss/ds are last word indices,
//                             sampled with start
//   busy, done, err           status: busy outside IDLE, done pulse, sticky err
//   mem_re, mem_ra, mem_rd    source memory read port (data one cycle later)
//   mem_we, mem_wa, mem_wd    result memory write port
//   src_valid/data/last/ready src stream master
//   dst_valid/data/last/ready dst stream slave
// -----------------------------------------------------------------------------
module batch_stream_host #(
   parameter int            AW       = 12,
   parameter int            DW       = 32,
   parameter logic [AW-1:0] DST_BASE = 'h800,
   parameter int            TMO_CYC  = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] ss,
   input  logic [AW-1:0] ds,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          mem_re,
   output logic [AW-1:0] mem_ra,
   input  logic [DW-1:0] mem_rd,
   output logic          mem_we,
   output logic [AW-1:0] mem_wa,
   output logic [DW-1:0] mem_wd,
   output logic          src_valid,
   output logic [DW-1:0] src_data,
   output logic          src_last,
   input  logic          src_ready,
   input  logic          dst_valid,
   input  logic [DW-1:0] dst_data,
   input  logic          dst_last,
   output logic          dst_ready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_RECV = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t          state;

   // Batch parameters captured at start
   logic [AW-1:0]   ss_q;
   logic [AW-1:0]   ds_q;

   // Read side: next address to issue and "every word issued" flag. The flag
   // is needed because ss can be the largest AW-bit value, so the address
   // counter alone cannot tell "finished" from "wrapped".
   logic [AW-1:0]   rd_addr;
   logic            rd_all;

   // Read in flight: mem_rd carries valid data during the cycle after mem_re
   logic            vld_p1;
   logic            last_p1;

   // 2-entry prefetch buffer
   logic [1:0][DW-1:0] buf_data;
   logic [1:0]         buf_last;
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         buf_cnt;
   logic [1:0]         cnt_next;
   logic               push;
   logic               pop;

   // Receive side
   logic [AW-1:0]   dst_cnt;
   logic            dst_beat;
   logic            end_cnt;

`ifdef STREAM_TIMEOUT_EN
   localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   logic [TW-1:0]   tmo_cnt;
`endif

   // ---------------------------------------------------------------- stage p0
   // Stream outputs come straight from the buffer head, so they hold steady
   // for as long as the beat is stalled.
   assign src_valid = (buf_cnt != 2'd0);
   assign src_data  = buf_data[rd_ptr];
   assign src_last  = src_valid & buf_last[rd_ptr];

   assign pop      = src_valid & src_ready;
   assign push     = vld_p1;
   assign cnt_next = buf_cnt + {1'b0, push} - {1'b0, pop};

   // cnt_next already counts the word now in flight. A new read may be issued
   // only if that word plus the new one still fit in the two entries.
   assign mem_re = (state == ST_SEND) && !rd_all && (cnt_next < 2'd2);
   assign mem_ra = rd_addr;

   assign dst_beat = (state == ST_RECV) && dst_ready && dst_valid;
   assign end_cnt  = (dst_cnt == ds_q);
   assign mem_we   = dst_beat;
   assign mem_wa   = DST_BASE + dst_cnt;
   assign mem_wd   = dst_data;

   // ---------------------------------------------------------------- stage p1
   // Buffer storage. Only the buffer count and pointers are reset.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr_ptr] <= mem_rd;
         buf_last[wr_ptr] <= last_p1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         dst_ready <= 1'b0;
         ss_q      <= '0;
         ds_q      <= '0;
         rd_addr   <= '0;
         rd_all    <= 1'b0;
         vld_p1    <= 1'b0;
         last_p1   <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         buf_cnt   <= 2'd0;
         dst_cnt   <= '0;
`ifdef STREAM_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         done    <= 1'b0;
         vld_p1  <= mem_re;
         last_p1 <= mem_re && (rd_addr == ss_q);
         if (mem_re) begin
            rd_addr <= rd_addr + AW'(1);
            if (rd_addr == ss_q)
               rd_all <= 1'b1;
         end
         if (push)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
         buf_cnt <= cnt_next;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  ss_q    <= ss;
                  ds_q    <= ds;
                  err     <= 1'b0;
                  rd_addr <= '0;
                  rd_all  <= 1'b0;
                  dst_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= ST_SEND;
               end
            end

            ST_SEND: begin
               // The last word is only ever the final buffered entry, so
               // the buffer is empty once its handshake completes.
               if (pop && src_last) begin
                  dst_ready <= 1'b1;
                  state     <= ST_RECV;
`ifdef STREAM_TIMEOUT_EN
                  tmo_cnt   <= '0;
`endif
               end
            end

            ST_RECV: begin
               if (dst_beat) begin
                  dst_cnt <= dst_cnt + AW'(1);
`ifdef STREAM_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
                  if (dst_last || end_cnt) begin
                     if (dst_last ^ end_cnt)
                        err <= 1'b1;
                     dst_ready <= 1'b0;
                     done      <= 1'b1;
                     state     <= ST_DONE;
                  end
               end
`ifdef STREAM_TIMEOUT_EN
               else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
                  err       <= 1'b1;
                  dst_ready <= 1'b0;
                  done      <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
`endif
            end

            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               busy      <= 1'b0;
               dst_ready <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_batch_stream_host.sv
// -----------------------------------------------------------------------------
// tb_batch_stream_host
//
// Bench for batch_stream_host. A reactive source memory returns a known word
// per address one cycle after mem_re; a sink replays a directed table of dst
// beats. A compare process checks every active cycle against a transaction
// model (expected word order, prefetch bound, write addresses/data, final err)
// and each batch ends with count checks plus hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_batch_stream_host;

   localparam int            AW   = 12;
   localparam int            DW   = 32;
   localparam logic [AW-1:0] BASE = 12'h800;
`ifdef STREAM_TIMEOUT_EN
   localparam int            TB_TMO = 16;
`else
   localparam int            TB_TMO = 1024;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] ss;
   logic [AW-1:0] ds;
   logic          busy;
   logic          done;
   logic          err;
   logic          mem_re;
   logic [AW-1:0] mem_ra;
   logic [DW-1:0] mem_rd;
   logic          mem_we;
   logic [AW-1:0] mem_wa;
   logic [DW-1:0] mem_wd;
   logic          src_valid;
   logic [DW-1:0] src_data;
   logic          src_last;
   logic          src_ready;
   logic          dst_valid;
   logic [DW-1:0] dst_data;
   logic          dst_last;
   logic          dst_ready;

   batch_stream_host #(
      .AW      (AW),
      .DW      (DW),
      .DST_BASE(BASE),
      .TMO_CYC (TB_TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .ss       (ss),
      .ds       (ds),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .mem_re   (mem_re),
      .mem_ra   (mem_ra),
      .mem_rd   (mem_rd),
      .mem_we   (mem_we),
      .mem_wa   (mem_wa),
      .mem_wd   (mem_wd),
      .src_valid(src_valid),
      .src_data (src_data),
      .src_last (src_last),
      .src_ready(src_ready),
      .dst_valid(dst_valid),
      .dst_data (dst_data),
      .dst_last (dst_last),
      .dst_ready(dst_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Sink table and source-ready pattern (0: always ready, 1: toggling)
   logic [DW-1:0] snk_data [8];
   logic          snk_last [8];
   int            snk_n    = 0;
   int            snk_idx  = 0;
   int            rdy_mode = 0;

   // Transaction model state
   bit            chk_en = 1'b0;
   int            m_ss, m_src_idx, m_rd_idx, m_wr_idx, m_done;
   logic          m_err_exp;
   int            exp_wr;
   int            first_beat_cyc, last_beat_cyc, done_cyc, start_cyc;
   logic [AW-1:0] first_wa;

   function automatic logic [DW-1:0] src_word(input logic [AW-1:0] a);
      return {16'hC0DE, 4'h0, a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},      busy,      0);
      chk({tag, "_done"},      done,      0);
      chk({tag, "_err"},       err,       0);
      chk({tag, "_mem_re"},    mem_re,    0);
      chk({tag, "_mem_we"},    mem_we,    0);
      chk({tag, "_src_valid"}, src_valid, 0);
      chk({tag, "_src_last"},  src_last,  0);
      chk({tag, "_dst_ready"}, dst_ready, 0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Source memory and sink driver: sample on the falling edge, drive 1 time
   // unit after the rising edge.
   initial begin
      logic          rd_hit;
      logic [AW-1:0] rd_a;
      logic          took;
      mem_rd    = '0;
      dst_valid = 1'b0;
      dst_data  = '0;
      dst_last  = 1'b0;
      src_ready = 1'b1;
      forever begin
         @(negedge clk);
         rd_hit = mem_re;
         rd_a   = mem_ra;
         took   = dst_valid && dst_ready;
         @(posedge clk);
         #1;
         mem_rd = rd_hit ? src_word(rd_a) : 32'hDEAD_BEEF;
         if (took) snk_idx++;
         if (snk_idx < snk_n) begin
            dst_valid = 1'b1;
            dst_data  = snk_data[snk_idx];
            dst_last  = snk_last[snk_idx];
         end else begin
            dst_valid = 1'b0;
            dst_data  = '0;
            dst_last  = 1'b0;
         end
         src_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      end
   end

   // Compare process
   initial begin
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      logic          prev_last;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_en && !rst) begin
            if (prev_stall) begin
               chk("stall_valid", src_valid, 1);
               chk("stall_data",  src_data,  prev_data);
               chk("stall_last",  src_last,  prev_last);
            end
            if (src_valid && src_ready) begin
               chk("src_data", src_data, src_word(AW'(m_src_idx)));
               chk("src_last", src_last, (m_src_idx == m_ss));
               if (m_src_idx == 0) first_beat_cyc = cyc;
               last_beat_cyc = cyc;
               m_src_idx++;
            end else if (!src_valid) begin
               chk("src_last_idle", src_last, 0);
            end
            if (mem_re) begin
               chk("mem_ra",         mem_ra, AW'(m_rd_idx));
               chk("rd_in_range",    (m_rd_idx <= m_ss), 1);
               chk("prefetch_bound", ((m_rd_idx + 1 - m_src_idx) <= 2), 1);
               m_rd_idx++;
            end
            chk("mem_we", mem_we, (dst_valid && dst_ready));
            if (mem_we) begin
               chk("mem_wa", mem_wa, BASE + AW'(m_wr_idx));
               chk("mem_wd", mem_wd, (m_wr_idx < 8) ? snk_data[m_wr_idx] : '0);
               if (m_wr_idx == 0) first_wa = mem_wa;
               m_wr_idx++;
            end
            if (done) begin
               chk("done_err",       err,       m_err_exp);
               chk("done_dst_ready", dst_ready, 0);
               chk("done_busy",      busy,      1);
               done_cyc = cyc;
               m_done++;
            end
            prev_stall = src_valid && !src_ready;
            prev_data  = src_data;
            prev_last  = src_last;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // Load sink table and derive the expected outcome: the batch ends on the
   // first beat that is last or has index ds; err if exactly one holds. With
   // no such beat the batch can only end by timeout (err, every beat written).
   task automatic prep(input int t_ss, input int t_ds, input int mode,
                       input int n_beats, input int last_at);
      bit found;
      for (int k = 0; k < 8; k++) begin
         snk_data[k] = {8'h5A, 8'(t_ss), 8'(t_ds), 8'(k)};
         snk_last[k] = (k == last_at);
      end
      found     = 1'b0;
      m_err_exp = 1'b1;
      exp_wr    = n_beats;
      for (int k = 0; k < n_beats; k++) begin
         if (!found && (snk_last[k] || k == t_ds)) begin
            found     = 1'b1;
            m_err_exp = snk_last[k] ^ (k == t_ds);
            exp_wr    = k + 1;
         end
      end
      rdy_mode  = mode;
      m_ss      = t_ss;
      m_src_idx = 0;
      m_rd_idx  = 0;
      m_wr_idx  = 0;
      m_done    = 0;
      snk_idx   = 0;
      snk_n     = n_beats;
      chk_en    = 1'b1;
      @(posedge clk);
      #2;
      ss        = AW'(t_ss);
      ds        = AW'(t_ds);
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clk);
      #2;
      start = 1'b0;
      ss    = '0;
      ds    = '0;
   endtask

   task automatic run_batch(input int t_ss, input int t_ds, input int mode,
                            input int n_beats, input int last_at, input bit glitch,
                            input string tag, input logic lit_err, input int lit_wr);
      prep(t_ss, t_ds, mode, n_beats, last_at);
      chk({tag, "_busy_on_start"}, busy, 1);
      chk({tag, "_err_cleared"},   err,  0);
      if (glitch) begin
         repeat (2) @(posedge clk);
         #2;
         ss    = 12'd2;
         ds    = 12'd0;
         start = 1'b1;
         @(posedge clk);
         #2;
         start = 1'b0;
      end
      for (int i = 0; i < 500 && m_done == 0; i++) begin
         @(posedge clk);
         #3;
      end
      repeat (2) @(posedge clk);
      #3;
      chk({tag, "_done_count"}, m_done,    1);
      chk({tag, "_src_beats"},  m_src_idx, t_ss + 1);
      chk({tag, "_mem_reads"},  m_rd_idx,  t_ss + 1);
      chk({tag, "_writes"},     m_wr_idx,  exp_wr);
      chk({tag, "_err"},        err,       m_err_exp);
      chk({tag, "_writes_lit"}, m_wr_idx,  lit_wr);
      chk({tag, "_err_lit"},    err,       lit_err);
      chk({tag, "_busy_end"},   busy,      0);
      if (mode == 0) begin
         chk({tag, "_first_latency"}, first_beat_cyc - start_cyc, 3);
         chk({tag, "_beat_span"},     last_beat_cyc - first_beat_cyc, t_ss);
      end
      chk_en = 1'b0;
      snk_n  = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      ss    = '0;
      ds    = '0;
      #2;
      rst = 1'b1;
      #1;
      chk_zero("reset_async");
      repeat (3) @(posedge clk);
      #2;
      chk_zero("reset_held");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk_zero("after_reset");

      // Four source words at full rate, sink ends on its 2nd beat with last
      run_batch(3, 1, 0, 2, 1, 1'b0, "t1", 1'b0, 2);
      chk("t1_first_wa", first_wa, 12'h800);

      // Toggling src_ready; single-beat receive with ds=0 and last
      run_batch(7, 0, 1, 1, 0, 1'b0, "t2", 1'b0, 1);

      // dst_last on beat 1 while ds=2: early end with error
      run_batch(1, 2, 0, 2, 1, 1'b0, "t3", 1'b1, 2);

      // Reset during SEND after two beats of ss=5, then a full batch
      prep(5, 0, 0, 1, 0);
      for (int i = 0; i < 100 && m_src_idx < 2; i++) begin
         @(posedge clk);
         #3;
      end
      chk("t4_beats_before_rst", m_src_idx, 2);
      chk_en = 1'b0;
      rst    = 1'b1;
      #1;
      chk_zero("t4_rst_now");
      @(posedge clk);
      #2;
      chk_zero("t4_rst_edge");
      rst   = 1'b0;
      snk_n = 0;
      repeat (2) @(posedge clk);
      run_batch(5, 0, 0, 1, 0, 1'b0, "t4", 1'b0, 1);

      // start pulsed (with other ss) mid-batch must be ignored
      run_batch(5, 2, 0, 3, 2, 1'b1, "t5", 1'b0, 3);

      // ss=0, ds=0, beat without last: ends on count, err set
      run_batch(0, 0, 0, 1, -1, 1'b0, "t7", 1'b1, 1);

`ifdef STREAM_TIMEOUT_EN
      // No dst beats at all: timeout after 16 idle RECV cycles
      run_batch(0, 3, 0, 0, -1, 1'b0, "t6", 1'b1, 0);
      chk("t6_timeout_cycles", done_cyc - last_beat_cyc, 17);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
